alu_mult_seq: RTL and testbench
===============================

Name: alu_mult_seq

Overview:
- Multi-cycle shift-add multiplier controller that time-shares the 32-bit ALU through its ALU port and fills the ALU's unimplemented multiply slot.
- Sequences the ALU add operation, plus sub/nor for signed fix-up when the optional feature is compiled in, to produce a 64-bit product into hi/lo.
- Sits beside the ALU in the execute stage. Decode asserts start for MULT/MULTU; hi/lo feed the MFHI/MFLO path.

Parameters:
- WIDTH, 32, operand width; only 32 is supported because it matches the ALU.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op_a  input  32  multiplicand; captured on accepted start.
- op_b  input  32  multiplier; captured on accepted start.
- mult_signed  input  1  1 = MULT, 0 = MULTU; captured on accepted start.
- busy  output  1  high from the cycle after accept until the last compute cycle.
- done  output  1  one-cycle pulse when hi/lo become valid.
- hi  output  32  product bits 63:32.
- lo  output  32  product bits 31:0.
- alu_a  output  32  ALU operand A.
- alu_b  output  32  ALU operand B.
- alu_sel  output  3  ALU select.
- alu_out  input  32  ALU result, combinational, same cycle.

Behaviour:
- Reset: state IDLE; hi, lo, busy, done, count and flags all 0. alu_a, alu_b and alu_sel are 0, which is add 0+0. Reset mid-operation aborts immediately and discards the partial product.
- States: IDLE, RUN, DONE; plus SGN_A, SGN_B, NEG_LO, NEG_HI, INC_HI when the feature is enabled.
- Accept:
  - start=1 in IDLE or DONE at edge t loads mcand=op_a, lo=op_b, hi=0, count=0.
  - Next state is RUN, or SGN_A for a signed request with the feature enabled.
  - start while busy is ignored: no capture and no effect.
- RUN, one iteration per cycle, 32 cycles:
  - alu_sel=000, alu_a=hi, alu_b=mcand.
  - If lo[0]=1: sum=alu_out and c = (hi[31]&mcand[31]) | ((hi[31]|mcand[31]) & ~sum[31]). Otherwise sum=hi and c=0.
  - Update {hi,lo} <= {c, sum, lo[31:1]}; count++.
  - When count=31, go to DONE (or NEG_LO when signed).
- DONE: done=1 for exactly one cycle. hi/lo hold until the next accepted start. Next state is IDLE, or RUN/SGN_A if start=1 in that cycle (back-to-back).
- busy=1 in every state except IDLE and DONE.
- Unsigned latency: start at edge t, done high during cycle t+33.
- Outside RUN and the fix-up states, alu_a=alu_b=0 and alu_sel=000.
- The ALU carry-out is not exported, so carry is always reconstructed as above.

Optional Feature:
- Macro: ALU_MULT_SIGNED_EN.
- Defined, with mult_signed=1 at accept:
  - At accept, also record neg = op_a[31]^op_b[31].
  - SGN_A: alu_sel=010, alu_a=0, alu_b=mcand. Write mcand=alu_out only if mcand[31].
  - SGN_B: same operation on lo.
  - RUN: 32 cycles as above.
  - NEG_LO: alu_sel=010, alu_a=0, alu_b=lo.
  - NEG_HI: alu_sel=101, alu_a=alu_b=hi.
  - INC_HI: alu_sel=000, alu_a=hi, alu_b=1. Write only if neg=1 and lo==0.
  - NEG_LO and NEG_HI write only if neg=1.
  - All states are always traversed, giving fixed latency: done during cycle t+38.
  - Operand 0x80000000 negates to itself and is treated as magnitude 2^31, so the result stays correct.
- Not defined: mult_signed is ignored, all requests are unsigned, and the signed states are not synthesised.

Decomposition:
- Shared package mult_pkg holds:
  - the state encoding;
  - ALU select constants ALU_ADD=3'b000, ALU_XOR=3'b001, ALU_SUB=3'b010, ALU_MUL=3'b011, ALU_SLT=3'b100, ALU_NOR=3'b101, ALU_AND=3'b110, ALU_OR=3'b111;
  - MULT_ITER=32.
- No sub-module: this block is pure FSM plus registers. The ALU is instantiated by the parent and wired through the alu_* ports.

Test Plan:
- op_a=3, op_b=5, unsigned, start at t -> busy during t+1..t+32; done only in t+33; hi=0x00000000, lo=0x0000000F.
- op_a=op_b=0xFFFFFFFF unsigned -> hi=0xFFFFFFFE, lo=0x00000001; checks carry reconstruction.
- Start pulses at t+5 and t+20 with different operands -> ignored; the result is from the first operands, with done still at t+33.
- rst_n low at t+10 -> hi/lo/busy/done=0 immediately, state IDLE; a fresh start afterwards completes normally.
- start held high during DONE with op_a=7, op_b=6 -> a second run begins with no IDLE cycle; done 33 cycles later with lo=0x2A.
- With ALU_MULT_SIGNED_EN, mult_signed=1:
  - op_a=0xFFFFFFFD (-3), op_b=5 -> done at t+38; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - op_a=0x80000000, op_b=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM states, ALU select codes, iteration count.
// The signed fix-up states exist only when ALU_MULT_SIGNED_EN is defined.
package mult_pkg;

    localparam int MULT_ITER = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_XOR = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_OR  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DONE   = 3'd2
`ifdef ALU_MULT_SIGNED_EN
        ,
        ST_SGN_A  = 3'd3,
        ST_SGN_B  = 3'd4,
        ST_NEG_LO = 3'd5,
        ST_NEG_HI = 3'd6,
        ST_INC_HI = 3'd7
`endif
    } state_e;

    // The ALU does not export its carry, so it is rebuilt from the operand and sum MSBs.
    function automatic logic add_carry(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
    endfunction

endpackage

// File: rtl/alu_mult_seq.sv
// Multi-cycle shift-add multiplier that borrows the execute-stage ALU through the alu_* ports.
// Define ALU_MULT_SIGNED_EN to add the signed (MULT) magnitude/negate fix-up states.
module alu_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mult_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum;
    logic               carry;
`ifdef ALU_MULT_SIGNED_EN
    logic               sgn_q, sgn_d;
    logic               neg_q, neg_d;
`else
    logic               unused_mult_signed;
    assign unused_mult_signed = mult_signed;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = ALU_ADD;
        sum     = hi_q;
        carry   = 1'b0;
`ifdef ALU_MULT_SIGNED_EN
        sgn_d   = sgn_q;
        neg_d   = neg_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    mcand_d = op_a;
                    lo_d    = op_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
`ifdef ALU_MULT_SIGNED_EN
                    sgn_d   = mult_signed;
                    neg_d   = mult_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    if (mult_signed) state_d = ST_SGN_A;
`endif
                end
            end

            ST_RUN: begin
                alu_a = hi_q;
                alu_b = mcand_q;
                if (lo_q[0]) begin
                    sum   = alu_out;
                    carry = add_carry(hi_q[WIDTH-1], mcand_q[WIDTH-1], alu_out[WIDTH-1]);
                end
                hi_d  = {carry, sum[WIDTH-1:1]};
                lo_d  = {sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MULT_ITER - 1)) begin
                    state_d = ST_DONE;
`ifdef ALU_MULT_SIGNED_EN
                    if (sgn_q) state_d = ST_NEG_LO;
`endif
                end
            end

`ifdef ALU_MULT_SIGNED_EN
            // Operands are reduced to magnitudes; 0x80000000 negates to itself = 2^31 unsigned.
            ST_SGN_A: begin
                alu_sel = ALU_SUB;
                alu_b   = mcand_q;
                if (mcand_q[WIDTH-1]) mcand_d = alu_out;
                state_d = ST_SGN_B;
            end

            ST_SGN_B: begin
                alu_sel = ALU_SUB;
                alu_b   = lo_q;
                if (lo_q[WIDTH-1]) lo_d = alu_out;
                state_d = ST_RUN;
            end

            // 64-bit negate as ~{hi,lo}+1: lo = 0-lo, hi = ~hi, then carry into hi when lo wrapped to 0.
            ST_NEG_LO: begin
                alu_sel = ALU_SUB;
                alu_b   = lo_q;
                if (neg_q) lo_d = alu_out;
                state_d = ST_NEG_HI;
            end

            ST_NEG_HI: begin
                alu_sel = ALU_NOR;
                alu_a   = hi_q;
                alu_b   = hi_q;
                if (neg_q) hi_d = alu_out;
                state_d = ST_INC_HI;
            end

            ST_INC_HI: begin
                alu_sel = ALU_ADD;
                alu_a   = hi_q;
                alu_b   = WIDTH'(1);
                if (neg_q && (lo_q == '0)) hi_d = alu_out;
                state_d = ST_DONE;
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
`ifdef ALU_MULT_SIGNED_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
`ifdef ALU_MULT_SIGNED_EN
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
`endif
        end
    end

    assign busy = !(state_q inside {ST_IDLE, ST_DONE});
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Randomized self-checking bench for alu_mult_seq with a behavioural ALU and a 64-bit product model.
// Honours ALU_MULT_SIGNED_EN the same way the design does.
module tb_alu_mult_seq;
    import mult_pkg::*;

`ifdef ALU_MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        mult_signed = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo, alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;

    int n_checks = 0;
    int n_errors = 0;

    alu_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .mult_signed(mult_signed), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // Stand-in for the execute-stage ALU.
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_XOR: alu_out = alu_a ^ alu_b;
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_SLT: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_NOR: alu_out = ~(alu_a | alu_b);
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            default: alu_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s && SIGNED_EN) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic int ref_lat(input logic s);
        return (s && SIGNED_EN) ? 38 : 33;
    endfunction

    // Drive a request so it is sampled at the next rising edge, then scramble the operand inputs.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        op_a = a; op_b = b; mult_signed = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; mult_signed = 1'($urandom);
    endtask

    // Watch one operation to completion; optionally inject ignored starts or chain a new request in DONE.
    task automatic await_result(input logic [63:0] exp, input int lat, input string tag,
                                input bit pulses, input bit chain,
                                input logic [31:0] ca, input logic [31:0] cb);
        int busy_cnt = 0;
        int done_at  = 0;
        logic [63:0] res = '0;
        logic [66:0] alu_idle = '0;
        for (int k = 1; k <= 60 && done_at == 0; k++) begin
            @(negedge clk);
            if (done) begin
                done_at  = k;
                res      = {hi, lo};
                alu_idle = {alu_a, alu_b, alu_sel};
                if (chain) begin
                    op_a = ca; op_b = cb; mult_signed = 1'b0; start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end else begin
                if (busy) busy_cnt++;
                if (pulses && (k == 5 || k == 20)) begin
                    op_a = $urandom; op_b = $urandom; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        check({tag, "_done_cycle"}, 64'(done_at), 64'(lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
        check({tag, "_product"}, res, exp);
        check({tag, "_alu_idle"}, 64'(alu_idle), 64'd0);
        if (!chain) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input string tag, input bit pulses);
        launch(a, b, s);
        await_result(ref_prod(a, b, s), ref_lat(s), tag, pulses, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, hi, lo}, 66'd0);
        check("reset_alu", {alu_a, alu_b, alu_sel}, 67'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", {busy, done, hi, lo}, 66'd0);

        run_op(32'd3, 32'd5, 1'b0, "u3x5", 1'b0);
        check("u3x5_lo_const", lo, 32'h0000000F);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "umax", 1'b0);
        check("umax_const", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, "ignored_starts", 1'b1);

        // Asynchronous reset in the middle of a run.
        launch(32'hDEADBEEF, 32'hCAFEF00D, 1'b0);
        repeat (9) @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {busy, done, hi, lo}, 66'd0);
        check("mid_reset_alu", {alu_a, alu_b, alu_sel}, 67'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd11, 32'd13, 1'b0, "after_reset", 1'b0);

        // Back-to-back: start held during DONE begins the next run with no IDLE cycle.
        launch(32'h0000FFFF, 32'h00010001, 1'b0);
        await_result(ref_prod(32'h0000FFFF, 32'h00010001, 1'b0), 33, "b2b_first", 1'b0, 1'b1, 32'd7, 32'd6);
        check("b2b_busy_next", busy, 1'b1);
        await_result(64'd42, 33, "b2b_second", 1'b0, 1'b0, '0, '0);

        // Signed requests (treated as unsigned unless the signed feature is built in).
        run_op(32'hFFFFFFFD, 32'd5, 1'b1, "s_m3x5", 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, "s_min_x_m1", 1'b0);
        run_op(32'h80000000, 32'h80000000, 1'b1, "s_min_sq", 1'b0);
        run_op(32'd0, 32'hFFFFFFF0, 1'b1, "s_zero", 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (i % 5 == 0) ra = 32'h80000000;
            if (i % 7 == 0) rb = 32'hFFFFFFFF;
            run_op(ra, rb, rs, $sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
